hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//  Parametrised hazard unit for the 5-stage MIPS pipeline with variable-latency units (div, load miss).
//  Forwarding and load-use/branch/jr stalls as before, plus a per-register pending scoreboard
//  and an exception FSM that drains outstanding long ops before redirecting the PC.
//  Sits beside the datapath; drives all stall, flush and forward selects plus the PC redirect.
// PARAMETERS
//  NREG      32            architectural registers; r0 is never pending or forwarded
//  RAW       $clog2(NREG)  register-index width
//  MAX_OUT   4             long ops outstanding at once, 1..15
//  EXC_VEC   32'hbfc00380  exception entry PC
//  ERET_CODE 32'h0000000e  ExceptType value meaning eret (target = EPCM)
// PORTS
//  clk          in  1   clock
//  rst          in  1   reset; asynchronous, active-high
//  RsD, RtD     in  RAW decode source regs
//  BranchD, JrD in  1   decode instr is branch / jr
//  RsE, RtE     in  RAW execute source regs
//  WriteRegE    in  RAW execute dest; RegWriteE, MemtoRegE in 1
//  IssueLongE   in  1   E instr starts a long op writing WriteRegE
//  WriteRegM    in  RAW mem dest; RegWriteM, MemtoRegM in 1
//  WriteRegW    in  RAW wb dest; RegWriteW in 1
//  DoneValid    in  1   a long op completes and writes DoneReg this cycle
//  DoneReg      in  RAW completing dest
//  ExceptSignal in  1   exception taken at M (one-cycle pulse)
//  ExceptType   in  32  cause code; EPCM in 32 return PC
//  StallF, StallD, StallE                out 1  hold stage registers
//  FlushF, FlushD, FlushE, FlushM, FlushW out 1  clear stage registers
//  ForwardAD, ForwardBD                  out 1  M-to-D forward for branch/jr compare
//  ForwardAE, ForwardBE                  out 2  00 regfile, 10 from M, 01 from W
//  PCRedirect   out 1   load NewPC into PC this cycle
//  NewPC        out 32  redirect target; Busy out 1 exception FSM not IDLE
// BEHAVIOUR
//  Reset: pending[] = 0, count = 0, state IDLE; all outputs 0, NewPC = 0.
//  Forwarding (comb): ForwardXE = 10 if src!=0 & src==WriteRegM & RegWriteM, else 01 if same vs W, else 00.
//    ForwardXD = src!=0 & src==WriteRegM & RegWriteM.
//  Scoreboard: on IssueLongE & ~StallE & ~FlushE & WriteRegE!=0 -> pending[WriteRegE]=1, count+1.
//    On DoneValid -> pending[DoneReg]=0, count-1. Both in one cycle with same reg: pending stays 1, count unchanged.
//    Done on a non-pending reg is ignored (no underflow); issue at count==MAX_OUT is blocked by StallE.
//  Stalls (IDLE only): LoadUse = MemtoRegE & (RtE==RsD | RtE==RtD).
//    BranchSt = BranchD & (RegWriteE & WriteRegE in {RsD,RtD} | MemtoRegM & WriteRegM in {RsD,RtD}).
//    JrSt = JrD & same terms on RsD only.
//    SbSt = pending[RsD] | pending[RtD] (r0 excluded); Full = IssueLongE & count==MAX_OUT.
//    StallD = StallF = any of the above; StallE = Full; FlushE = (LoadUse|BranchSt|JrSt|SbSt) & ~Full.
//  Exception FSM IDLE->FLUSH->(DRAIN)->REDIRECT->IDLE:
//    IDLE: ExceptSignal -> FLUSH, latching target = (ExceptType==ERET_CODE) ? EPCM : EXC_VEC.
//    FLUSH (1 cycle): FlushF..FlushW = 1, all issue suppressed; -> DRAIN if count!=0, else REDIRECT.
//    DRAIN: StallF=StallD=1, FlushE=1; completions still retire; -> REDIRECT once count==0.
//    REDIRECT (1 cycle): PCRedirect=1, NewPC=target, FlushD=1; -> IDLE.
//    ExceptSignal outside IDLE is ignored. Busy = state!=IDLE.
//  Latency: stalls/forwards combinational; pending visible the cycle after issue.
//    DoneValid in cycle t clears the SbSt stall in t (bypass: Done reg is not pending to D).
//  Async rst mid-DRAIN: scoreboard cleared, FSM IDLE, no redirect issued.
// STRUCTURE
//  hazard_pkg: FWD_RF/FWD_M/FWD_W encodings, exc_state_t enum, EXC_VEC/ERET_CODE defaults.
//  Sub-module hazard_sb_regs: pending vector + outstanding counter (issue/done/clear ports).
//  Forwarding, stall logic and FSM stay in the top.
// TESTING
//  1 lw r2 in E, add RsD=r2 -> StallF=StallD=FlushE=1 one cycle, then ForwardAE=10 next cycle.
//  2 IssueLongE r5, add RsD=r5 two cycles later -> StallD until DoneValid r5, released same cycle.
//  3 MAX_OUT=4: issue r1..r4, 5th IssueLongE -> StallE=1; DoneValid r1 -> StallE=0 next cycle.
//  4 r3 pending, ExceptSignal type 0x8 -> FLUSH 1 cycle, DRAIN, DoneValid r3 -> PCRedirect, NewPC=bfc00380.
//  5 ExceptType 0xe, EPCM=0x80001234, count 0 -> FLUSH then REDIRECT, NewPC=0x80001234, Busy 2 cycles.
//  6 Issue and Done r7 same cycle -> pending[r7]=1, count unchanged; rst in DRAIN -> all outputs 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forward-select codes, exception FSM
// states and default exception vectors.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

    localparam logic [31:0] EXC_VEC_DEFAULT   = 32'hbfc00380;
    localparam logic [31:0] ERET_CODE_DEFAULT = 32'h0000000e;

    typedef enum logic [1:0] {
        EXC_IDLE,
        EXC_FLUSH,
        EXC_DRAIN,
        EXC_REDIRECT
    } exc_state_t;

endpackage

// File: rtl/hazard_sb_regs.sv
// Per-register pending bits and outstanding long-op counter; a completion only
// retires a register that is actually pending, so the counter cannot underflow.
module hazard_sb_regs #(
    parameter int NREG    = 32,
    parameter int RAW     = $clog2(NREG),
    parameter int MAX_OUT = 4,
    parameter int CW      = $clog2(MAX_OUT + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clear_i,
    input  logic            issue_i,
    input  logic [RAW-1:0]  issue_reg_i,
    input  logic            done_i,
    input  logic [RAW-1:0]  done_reg_i,
    output logic [NREG-1:0] pending_o,
    output logic [CW-1:0]   count_o
);

    logic [NREG-1:0] pending_q, pending_d;
    logic [CW-1:0]   count_q, count_d;
    logic            issueEff;
    logic            doneEff;

    // A simultaneous issue and done on the same register nets to "still pending".
    always_comb begin
        issueEff  = issue_i && (issue_reg_i != '0);
        doneEff   = done_i && pending_q[done_reg_i];
        pending_d = pending_q;
        count_d   = count_q;
        if (doneEff) begin
            pending_d[done_reg_i] = 1'b0;
        end
        if (issueEff) begin
            pending_d[issue_reg_i] = 1'b1;
        end
        pending_d[0] = 1'b0;
        case ({issueEff, doneEff})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clear_i) begin
            pending_d = '0;
            count_d   = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign pending_o = pending_q;
    assign count_o   = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: forwarding, load-use/branch/jr stalls,
// a long-op scoreboard and an exception FSM that drains long ops before redirecting.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int          NREG      = 32,
    parameter int          RAW       = $clog2(NREG),
    parameter int          MAX_OUT   = 4,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT,
    parameter logic [31:0] ERET_CODE = ERET_CODE_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [RAW-1:0] RsD,
    input  logic [RAW-1:0] RtD,
    input  logic           BranchD,
    input  logic           JrD,
    input  logic [RAW-1:0] RsE,
    input  logic [RAW-1:0] RtE,
    input  logic [RAW-1:0] WriteRegE,
    input  logic           RegWriteE,
    input  logic           MemtoRegE,
    input  logic           IssueLongE,
    input  logic [RAW-1:0] WriteRegM,
    input  logic           RegWriteM,
    input  logic           MemtoRegM,
    input  logic [RAW-1:0] WriteRegW,
    input  logic           RegWriteW,
    input  logic           DoneValid,
    input  logic [RAW-1:0] DoneReg,
    input  logic           ExceptSignal,
    input  logic [31:0]    ExceptType,
    input  logic [31:0]    EPCM,
    output logic           StallF,
    output logic           StallD,
    output logic           StallE,
    output logic           FlushF,
    output logic           FlushD,
    output logic           FlushE,
    output logic           FlushM,
    output logic           FlushW,
    output logic           ForwardAD,
    output logic           ForwardBD,
    output logic [1:0]     ForwardAE,
    output logic [1:0]     ForwardBE,
    output logic           PCRedirect,
    output logic [31:0]    NewPC,
    output logic           Busy
);

    localparam int CW = $clog2(MAX_OUT + 1);

    exc_state_t      state_q, state_d;
    logic [31:0]     target_q, target_d;
    logic [NREG-1:0] pending;
    logic [CW-1:0]   count;
    logic            issue;
    logic            loadUse, branchSt, jrSt, sbSt, full, hazard;
    logic            pendRs, pendRt;

    hazard_sb_regs #(
        .NREG    (NREG),
        .RAW     (RAW),
        .MAX_OUT (MAX_OUT),
        .CW      (CW)
    ) u_sb_regs (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (1'b0),
        .issue_i     (issue),
        .issue_reg_i (WriteRegE),
        .done_i      (DoneValid),
        .done_reg_i  (DoneReg),
        .pending_o   (pending),
        .count_o     (count)
    );

    always_comb begin
        ForwardAE = FWD_RF;
        if (RsE != '0 && RsE == WriteRegM && RegWriteM) begin
            ForwardAE = FWD_M;
        end else if (RsE != '0 && RsE == WriteRegW && RegWriteW) begin
            ForwardAE = FWD_W;
        end
        ForwardBE = FWD_RF;
        if (RtE != '0 && RtE == WriteRegM && RegWriteM) begin
            ForwardBE = FWD_M;
        end else if (RtE != '0 && RtE == WriteRegW && RegWriteW) begin
            ForwardBE = FWD_W;
        end
    end

    assign ForwardAD = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
    assign ForwardBD = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;

    // A register completing this cycle is already visible to decode through the bypass.
    assign pendRs = (RsD != '0) && pending[RsD] && !(DoneValid && DoneReg == RsD);
    assign pendRt = (RtD != '0) && pending[RtD] && !(DoneValid && DoneReg == RtD);

    assign loadUse  = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
    assign branchSt = BranchD &&
                      ((RegWriteE && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                       (MemtoRegM && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    assign jrSt     = JrD && ((RegWriteE && (WriteRegE == RsD)) ||
                              (MemtoRegM && (WriteRegM == RsD)));
    assign sbSt     = pendRs || pendRt;
    assign full     = IssueLongE && (count == CW'(MAX_OUT));
    assign hazard   = loadUse || branchSt || jrSt || sbSt;

    assign issue = IssueLongE && !StallE && !FlushE;

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        FlushF     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushM     = 1'b0;
        FlushW     = 1'b0;
        PCRedirect = 1'b0;
        NewPC      = '0;
        case (state_q)
            EXC_IDLE: begin
                StallF = hazard || full;
                StallD = hazard || full;
                StallE = full;
                FlushE = hazard && !full;
                if (ExceptSignal) begin
                    state_d  = EXC_FLUSH;
                    target_d = (ExceptType == ERET_CODE) ? EPCM : EXC_VEC;
                end
            end
            EXC_FLUSH: begin
                FlushF  = 1'b1;
                FlushD  = 1'b1;
                FlushE  = 1'b1;
                FlushM  = 1'b1;
                FlushW  = 1'b1;
                state_d = (count != '0) ? EXC_DRAIN : EXC_REDIRECT;
            end
            EXC_DRAIN: begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
                if (count == '0) begin
                    state_d = EXC_REDIRECT;
                end
            end
            EXC_REDIRECT: begin
                PCRedirect = 1'b1;
                NewPC      = target_q;
                FlushD     = 1'b1;
                state_d    = EXC_IDLE;
            end
            default: state_d = EXC_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= EXC_IDLE;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    assign Busy = (state_q != EXC_IDLE);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: direct checks of stall/forward
// outputs plus a queue of expected redirect targets popped on each PCRedirect.
module tb_hazard_scoreboard;

    logic        clk, rst;
    logic [4:0]  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, DoneReg;
    logic        BranchD, JrD, RegWriteE, MemtoRegE, IssueLongE;
    logic        RegWriteM, MemtoRegM, RegWriteW, DoneValid, ExceptSignal;
    logic [31:0] ExceptType, EPCM;
    logic        StallF, StallD, StallE, FlushF, FlushD, FlushE, FlushM, FlushW;
    logic        ForwardAD, ForwardBD, PCRedirect, Busy;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] NewPC;
    logic [7:0]  ctl;
    logic [7:0]  misc;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] expectedPc[$];
    int          busyCycles;

    localparam logic [7:0] CTL_NONE  = 8'b0000_0000;
    localparam logic [7:0] CTL_STALL = 8'b1100_0100;
    localparam logic [7:0] CTL_FULL  = 8'b1110_0000;
    localparam logic [7:0] CTL_FLUSH = 8'b0001_1111;
    localparam logic [7:0] CTL_REDIR = 8'b0000_1000;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .RsD          (RsD),
        .RtD          (RtD),
        .BranchD      (BranchD),
        .JrD          (JrD),
        .RsE          (RsE),
        .RtE          (RtE),
        .WriteRegE    (WriteRegE),
        .RegWriteE    (RegWriteE),
        .MemtoRegE    (MemtoRegE),
        .IssueLongE   (IssueLongE),
        .WriteRegM    (WriteRegM),
        .RegWriteM    (RegWriteM),
        .MemtoRegM    (MemtoRegM),
        .WriteRegW    (WriteRegW),
        .RegWriteW    (RegWriteW),
        .DoneValid    (DoneValid),
        .DoneReg      (DoneReg),
        .ExceptSignal (ExceptSignal),
        .ExceptType   (ExceptType),
        .EPCM         (EPCM),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .FlushF       (FlushF),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushM       (FlushM),
        .FlushW       (FlushW),
        .ForwardAD    (ForwardAD),
        .ForwardBD    (ForwardBD),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .PCRedirect   (PCRedirect),
        .NewPC        (NewPC),
        .Busy         (Busy)
    );

    assign ctl  = {StallF, StallD, StallE, FlushF, FlushD, FlushE, FlushM, FlushW};
    assign misc = {Busy, PCRedirect, ForwardAE, ForwardBE, ForwardAD, ForwardBD};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0; DoneReg = '0;
        BranchD = 1'b0; JrD = 1'b0; RegWriteE = 1'b0; MemtoRegE = 1'b0;
        IssueLongE = 1'b0; RegWriteM = 1'b0; MemtoRegM = 1'b0; RegWriteW = 1'b0;
        DoneValid = 1'b0; ExceptSignal = 1'b0; ExceptType = '0; EPCM = '0;
    endtask

    // Advance to the drive point just after the next rising edge.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic waitRedirect(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (PCRedirect) begin
                seen = 1'b1;
                break;
            end
        end
        checkOutput(tag, {31'b0, seen}, 32'd1);
    endtask

    // Every redirect must match the oldest outstanding expected target.
    always @(negedge clk) begin
        if (!rst && PCRedirect) begin
            if (expectedPc.size() == 0) begin
                checkOutput("redirect_unexpected", {31'b0, PCRedirect}, 32'd0);
            end else begin
                checkOutput("redirect_pc", NewPC, expectedPc.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearInputs();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_ctl", ctl, CTL_NONE);
        checkOutput("rst_misc", misc, 0);
        checkOutput("rst_newpc", NewPC, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Load-use followed by forwarding from M and W
        MemtoRegE = 1'b1; RegWriteE = 1'b1; WriteRegE = 5'd2; RtE = 5'd2; RsD = 5'd2; RtD = 5'd3;
        @(negedge clk);
        checkOutput("loaduse_ctl", ctl, CTL_STALL);
        applyStimulus(); clearInputs();
        RegWriteM = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd2; RsE = 5'd2; RtE = 5'd3;
        RegWriteW = 1'b1; WriteRegW = 5'd3;
        @(negedge clk);
        checkOutput("fwd_ae_m", ForwardAE, 2'b10);
        checkOutput("fwd_be_w", ForwardBE, 2'b01);
        checkOutput("after_loaduse_ctl", ctl, CTL_NONE);

        applyStimulus(); clearInputs();
        RegWriteM = 1'b1; WriteRegM = 5'd6; RegWriteW = 1'b1; WriteRegW = 5'd6;
        RsE = 5'd6; RsD = 5'd6;
        @(negedge clk);
        checkOutput("fwd_m_priority", ForwardAE, 2'b10);
        checkOutput("fwd_be_none", ForwardBE, 2'b00);
        checkOutput("fwd_ad_bd", {ForwardAD, ForwardBD}, 2'b10);

        applyStimulus(); clearInputs();
        RegWriteM = 1'b1; RegWriteW = 1'b1;
        @(negedge clk);
        checkOutput("fwd_r0", {ForwardAE, ForwardBE, ForwardAD, ForwardBD}, 0);

        // Branch and jr stalls
        applyStimulus(); clearInputs();
        BranchD = 1'b1; RsD = 5'd1; RtD = 5'd4; RegWriteE = 1'b1; WriteRegE = 5'd4;
        @(negedge clk);
        checkOutput("branch_e_ctl", ctl, CTL_STALL);
        applyStimulus(); clearInputs();
        BranchD = 1'b1; RsD = 5'd8; MemtoRegM = 1'b1; RegWriteM = 1'b1; WriteRegM = 5'd8;
        @(negedge clk);
        checkOutput("branch_m_ctl", ctl, CTL_STALL);
        applyStimulus(); clearInputs();
        JrD = 1'b1; RsD = 5'd1; RtD = 5'd4; RegWriteE = 1'b1; WriteRegE = 5'd4;
        @(negedge clk);
        checkOutput("jr_rt_ignored", ctl, CTL_NONE);
        RsD = 5'd4;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("jr_rs_ctl", ctl, CTL_STALL);

        // Scoreboard stall released by same-cycle completion
        applyStimulus(); clearInputs();
        IssueLongE = 1'b1; WriteRegE = 5'd5;
        applyStimulus(); clearInputs();
        RsD = 5'd5;
        @(negedge clk);
        checkOutput("sb_stall", ctl, CTL_STALL);
        applyStimulus();
        @(negedge clk);
        checkOutput("sb_hold", ctl, CTL_STALL);
        applyStimulus();
        DoneValid = 1'b1; DoneReg = 5'd5;
        @(negedge clk);
        checkOutput("sb_bypass", ctl, CTL_NONE);
        applyStimulus(); clearInputs();
        RtD = 5'd5;
        @(negedge clk);
        checkOutput("sb_cleared", ctl, CTL_NONE);

        // Outstanding limit
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(); clearInputs();
            IssueLongE = 1'b1; WriteRegE = 5'(i);
        end
        applyStimulus(); clearInputs();
        IssueLongE = 1'b1; WriteRegE = 5'd6;
        @(negedge clk);
        checkOutput("full_ctl", ctl, CTL_FULL);
        applyStimulus();
        DoneValid = 1'b1; DoneReg = 5'd1;
        @(negedge clk);
        checkOutput("full_done_cycle", ctl, CTL_FULL);
        applyStimulus();
        DoneValid = 1'b0;
        @(negedge clk);
        checkOutput("full_release", ctl, CTL_NONE);
        foreach (expectedPc[i]) begin end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(); clearInputs();
            DoneValid = 1'b1;
            DoneReg   = (i == 3) ? 5'd6 : 5'(i + 2);
        end

        // Issue and done on the same register in one cycle
        applyStimulus(); clearInputs();
        IssueLongE = 1'b1; WriteRegE = 5'd7;
        applyStimulus();
        DoneValid = 1'b1; DoneReg = 5'd7;
        applyStimulus(); clearInputs();
        RsD = 5'd7;
        @(negedge clk);
        checkOutput("issue_done_pending", ctl, CTL_STALL);
        for (int r = 8; r <= 10; r++) begin
            applyStimulus(); clearInputs();
            IssueLongE = 1'b1; WriteRegE = 5'(r);
        end
        applyStimulus(); clearInputs();
        IssueLongE = 1'b1; WriteRegE = 5'd11;
        @(negedge clk);
        checkOutput("count_after_issue_done", ctl, CTL_FULL);
        for (int r = 7; r <= 10; r++) begin
            applyStimulus(); clearInputs();
            DoneValid = 1'b1; DoneReg = 5'(r);
        end

        // Exception with a long op outstanding: flush, drain, redirect to vector
        applyStimulus(); clearInputs();
        IssueLongE = 1'b1; WriteRegE = 5'd3;
        applyStimulus(); clearInputs();
        ExceptSignal = 1'b1; ExceptType = 32'h8; EPCM = 32'h8000_0040;
        expectedPc.push_back(32'hbfc00380);
        @(negedge clk);
        checkOutput("exc_idle_busy", {31'b0, Busy}, 32'd0);
        applyStimulus(); clearInputs();
        @(negedge clk);
        checkOutput("exc_flush_ctl", ctl, CTL_FLUSH);
        checkOutput("exc_flush_busy", {31'b0, Busy}, 32'd1);
        applyStimulus();
        ExceptSignal = 1'b1; ExceptType = 32'he; EPCM = 32'h1234_5678;
        @(negedge clk);
        checkOutput("exc_drain_ctl", ctl, CTL_STALL);
        checkOutput("exc_drain_noredir", {31'b0, PCRedirect}, 32'd0);
        applyStimulus(); clearInputs();
        DoneValid = 1'b1; DoneReg = 5'd3;
        applyStimulus(); clearInputs();
        waitRedirect("exc_redirect_seen");
        checkOutput("exc_redirect_ctl", ctl, CTL_REDIR);
        applyStimulus();
        @(negedge clk);
        checkOutput("exc_back_idle", {31'b0, Busy}, 32'd0);

        // eret with nothing outstanding
        applyStimulus(); clearInputs();
        ExceptSignal = 1'b1; ExceptType = 32'he; EPCM = 32'h8000_1234;
        expectedPc.push_back(32'h8000_1234);
        busyCycles = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            busyCycles += int'(Busy);
            applyStimulus(); clearInputs();
        end
        checkOutput("eret_busy_cycles", busyCycles, 2);

        // Asynchronous reset while draining
        IssueLongE = 1'b1; WriteRegE = 5'd9;
        applyStimulus(); clearInputs();
        ExceptSignal = 1'b1; ExceptType = 32'h8;
        applyStimulus(); clearInputs();
        applyStimulus();
        @(negedge clk);
        checkOutput("pre_rst_drain_busy", {31'b0, Busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_drain_ctl", ctl, CTL_NONE);
        checkOutput("rst_drain_misc", misc, 0);
        checkOutput("rst_drain_newpc", NewPC, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        RsD = 5'd9;
        @(negedge clk);
        checkOutput("rst_cleared_sb", ctl, CTL_NONE);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(); clearInputs();
        end
        @(negedge clk);
        checkOutput("rst_stays_idle", {31'b0, Busy}, 32'd0);

        checkOutput("sb_queue_empty", expectedPc.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
